sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
Shares one single-port, 1024x20 SRAM macro between a read requester and a masked-write requester. The macro has one RW port, a 10-bit write mask with 2-bit granules, and 1-cycle registered-address read latency. The block sits directly in front of the macro wrapper. It drives the macro's addr/en/wmode/wmask/wdata and returns read data with a fixed latency. It arbitrates with read priority plus a write anti-starvation bound, and orders same-address conflicts.

Parameters:
ADDR_W, 10, SRAM address width (depth = 2**ADDR_W)
DATA_W, 20, SRAM data width
MASK_W, 10, write-mask granules (DATA_W/MASK_W bits each)
STARVE_LIMIT, 4, consecutive write-stall cycles before write is forced ahead of reads (1..15)

Ports:
clock  in  1  core clock; also drives the macro clock
reset  in  1  asynchronous, active-high reset
rd_req_valid  in  1  read request
rd_req_ready  out  1  read accepted this cycle
rd_req_addr  in  ADDR_W  read address
rd_resp_valid  out  1  read data valid (no backpressure)
rd_resp_data  out  DATA_W  read data
wr_req_valid  in  1  write request
wr_req_ready  out  1  write accepted this cycle
wr_req_addr  in  ADDR_W  write address
wr_req_data  in  DATA_W  write data
wr_req_mask  in  MASK_W  per-granule write enable
sram_addr  out  ADDR_W  macro address
sram_en  out  1  macro enable
sram_wmode  out  1  1 = write, 0 = read
sram_wmask  out  MASK_W  macro write mask
sram_wdata  out  DATA_W  macro write data
sram_rdata  in  DATA_W  macro read data (valid the cycle after a read enable)
init_done  out  1  arbiter accepting requests

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: all readies 0, rd_resp_valid 0, sram_en 0, sram_wmode 0, starve counter 0, init_done 0.
- States: INIT, RUN. After reset releases, the block enters INIT; the optional feature defines INIT's length.
- Grants: at most one grant per cycle, in RUN only. The macro port is driven combinationally in the grant cycle: sram_en=1 and sram_addr/wmode/wmask/wdata come from the winner.
- Priority:
  - If only one request is valid, it wins.
  - If both are valid, read wins, except in these cases, where write wins:
    - the starve counter has reached STARVE_LIMIT, or
    - rd_req_addr == wr_req_addr (read then returns the new data).
- Starve counter:
  - increments, saturating at STARVE_LIMIT, on each cycle wr_req_valid is set and write is not granted;
  - clears on a write grant or when wr_req_valid drops.
- Ready semantics: ready=1 only for the granted requester in that cycle, and is independent of the other side's ready.
- Read latency: rd_resp_valid=1 exactly 1 cycle after a read grant. rd_resp_data = sram_rdata in that cycle (pass-through, unregistered). Back-to-back reads give one response per cycle.
- Masks:
  - The write mask passes unchanged.
  - A zero-mask write is still granted and issued, and modifies no data.
- Idle: when no grant occurs, sram_en=0 and the other macro outputs hold their last values (don't care).
- Reset mid-operation: an in-flight read response is dropped (rd_resp_valid forced 0). Partial INIT restarts from address 0.

Optional Feature:
Macro SRAM_ARB_INIT_CLEAR_EN.
- Defined: INIT sweeps addresses 0..2**ADDR_W-1, one per cycle. Each cycle issues a write with wdata=0 and an all-ones mask, with both readies 0 throughout. After the last address (1024 cycles), init_done rises on the next cycle, together with entry to RUN.
- Undefined: INIT lasts exactly 1 cycle after reset deassert, then init_done=1 and RUN; the macro contents are untouched.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum (INIT, RUN);
  - default widths ADDR_W/DATA_W/MASK_W;
  - STARVE_CNT_W = 4 constant;
  - a grant-source enum (NONE, RD, WR, INIT).
- One sub-module, sram_init_sweeper, contains the address counter, the sweep-done flag and the zero-write command. It is instantiated only under the macro.

Test Plan:
- Init, macro defined: release reset -> 1024 writes, sram_addr 0..1023, wmask 0x3FF, wdata 0; init_done=1 at cycle 1025; readies 0 before that.
- Read priority: both valid, rd addr 5, wr addr 9, STARVE_LIMIT 4 -> reads granted for 4 cycles, write granted on the 5th cycle, counter clears.
- Same-address ordering: write 0xABCDE to addr 3 with full mask, and a read of addr 3, both in the same cycle -> write granted first; the read is granted next cycle and rd_resp_data=0xABCDE one cycle later.
- Partial mask: preload addr 7 with 0xFFFFF, write 0x00000 with mask 0x001, read back -> 0xFFFFC.
- Back-to-back reads: addrs 0,1,2 over consecutive cycles -> rd_resp_valid high for 3 cycles with the matching data, 1 cycle behind each grant.
- Reset mid-read: assert reset in the cycle after a read grant -> rd_resp_valid=0 immediately; INIT restarts at address 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the single-port SRAM arbiter.
//   - default macro geometry (1024 x 20, 10 mask granules)
//   - width of the write starvation counter
//   - arbiter state enum (INIT, RUN)
//   - grant-source enum (NONE, RD, WR, INIT)
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 20;
    localparam int DEF_MASK_W   = 10;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2,
        GNT_INIT = 2'd3
    } gnt_src_e;

endpackage

// File: rtl/sram_init_sweeper.sv
// -----------------------------------------------------------------------------
// sram_init_sweeper
// Walks every macro address once, producing an all-ones-mask zero write per
// cycle while enabled. Used only when SRAM_ARB_INIT_CLEAR_EN is defined.
// Ports:
//   clock, reset    core clock, asynchronous active-high reset
//   sweep_en_i      advance the sweep this cycle (write is being issued)
//   sweep_addr_o    address of the current clear write
//   sweep_wdata_o   clear data (all zeros)
//   sweep_wmask_o   clear mask (all granules)
//   sweep_done_o    current write is the last address of the sweep
// -----------------------------------------------------------------------------
module sram_init_sweeper
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DEF_MASK_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sweep_en_i,
    output logic [ADDR_W-1:0] sweep_addr_o,
    output logic [DATA_W-1:0] sweep_wdata_o,
    output logic [MASK_W-1:0] sweep_wmask_o,
    output logic              sweep_done_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (sweep_en_i) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // A reset in the middle of a sweep restarts it from address 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign sweep_addr_o  = addr_q;
    assign sweep_wdata_o = '0;
    assign sweep_wmask_o = '1;
    assign sweep_done_o  = sweep_en_i && (addr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/sram_1rw_arbiter.sv
// -----------------------------------------------------------------------------
// sram_1rw_arbiter
// Shares one single-port SRAM macro (1-cycle read latency, granule write mask)
// between a read requester and a masked-write requester. Read has priority,
// except when the write has stalled STARVE_LIMIT cycles or both target the
// same address (write goes first so the read returns the new data).
//
// Optional feature: define SRAM_ARB_INIT_CLEAR_EN to zero the whole macro in
// INIT (one write per address); otherwise INIT lasts a single cycle.
//
// Ports:
//   clock, reset                  core/macro clock, async active-high reset
//   rd_req_valid/ready/addr       read request handshake
//   rd_resp_valid/data            read response, one cycle after the grant
//   wr_req_valid/ready/addr/data/mask   masked write request handshake
//   sram_addr/en/wmode/wmask/wdata      macro command (driven in grant cycle)
//   sram_rdata                    macro read data
//   init_done                     arbiter is in RUN and accepting requests
// -----------------------------------------------------------------------------
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MASK_W       = DEF_MASK_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [MASK_W-1:0] wr_req_mask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    gnt_src_e                gnt_src;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    rd_resp_valid_q;
    logic                    write_wins;

    // Last command driven to the macro; replayed on idle cycles so the macro
    // inputs only toggle when something is actually issued.
    logic [ADDR_W-1:0] addr_q;
    logic              wmode_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] wdata_q;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_addr;
    logic [DATA_W-1:0] sweep_wdata;
    logic [MASK_W-1:0] sweep_wmask;
    logic              sweep_done;

    // INIT is the reset state, so gate on the reset pin itself to keep the
    // macro quiet while reset is still asserted.
    assign sweep_en = (state_q == ST_INIT) && !reset;

    sram_init_sweeper #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MASK_W (MASK_W)
    ) u_sweeper (
        .clock         (clock),
        .reset         (reset),
        .sweep_en_i    (sweep_en),
        .sweep_addr_o  (sweep_addr),
        .sweep_wdata_o (sweep_wdata),
        .sweep_wmask_o (sweep_wmask),
        .sweep_done_o  (sweep_done)
    );
`endif

    // Same-address conflict: issue the write first so the read sees new data.
    assign write_wins = wr_req_valid &&
                        (!rd_req_valid || (starve_q >= STARVE_MAX) ||
                         (rd_req_addr == wr_req_addr));

    always_comb begin
        state_d = state_q;
        gnt_src = GNT_NONE;
        case (state_q)
            ST_INIT: begin
`ifdef SRAM_ARB_INIT_CLEAR_EN
                if (sweep_en) begin
                    gnt_src = GNT_INIT;
                end
                if (sweep_done) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (write_wins) begin
                    gnt_src = GNT_WR;
                end else if (rd_req_valid) begin
                    gnt_src = GNT_RD;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Counts consecutive cycles a pending write was passed over.
    always_comb begin
        starve_d = '0;
        if (wr_req_valid && (gnt_src != GNT_WR)) begin
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX
                                                : starve_q + STARVE_CNT_W'(1);
        end
    end

    always_comb begin
        sram_en    = (gnt_src != GNT_NONE);
        sram_addr  = addr_q;
        sram_wmode = wmode_q;
        sram_wmask = wmask_q;
        sram_wdata = wdata_q;
        case (gnt_src)
            GNT_RD: begin
                sram_addr  = rd_req_addr;
                sram_wmode = 1'b0;
            end
            GNT_WR: begin
                sram_addr  = wr_req_addr;
                sram_wmode = 1'b1;
                sram_wmask = wr_req_mask;
                sram_wdata = wr_req_data;
            end
`ifdef SRAM_ARB_INIT_CLEAR_EN
            GNT_INIT: begin
                sram_addr  = sweep_addr;
                sram_wmode = 1'b1;
                sram_wmask = sweep_wmask;
                sram_wdata = sweep_wdata;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_INIT;
            starve_q        <= '0;
            rd_resp_valid_q <= 1'b0;
            addr_q          <= '0;
            wmode_q         <= 1'b0;
            wmask_q         <= '0;
            wdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            starve_q        <= starve_d;
            rd_resp_valid_q <= (gnt_src == GNT_RD);
            addr_q          <= sram_addr;
            wmode_q         <= sram_wmode;
            wmask_q         <= sram_wmask;
            wdata_q         <= sram_wdata;
        end
    end

    assign rd_req_ready  = (gnt_src == GNT_RD);
    assign wr_req_ready  = (gnt_src == GNT_WR);
    // Macro output is already registered inside the macro; pass it straight on.
    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_resp_data  = sram_rdata;
    assign init_done     = (state_q == ST_RUN);

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw_arbiter
// Randomized + directed bench for sram_1rw_arbiter with a behavioural macro
// model. The driver predicts each cycle's grant and read data from the
// arbitration rules and a flat memory image and queues them; a monitor pops
// the queues and compares against the DUT. Honors SRAM_ARB_INIT_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_sram_1rw_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 20;
    localparam int MW    = 10;
    localparam int GW    = DW / MW;
    localparam int SL    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam int EXP_INIT_N = 1025;
`else
    localparam int EXP_INIT_N = 2;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic          wr_req_valid = 1'b0;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic [MW-1:0] wr_req_mask = '0;
    logic [AW-1:0] sram_addr;
    logic          sram_en;
    logic          sram_wmode;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          init_done;

    always #5 clock = ~clock;

    sram_1rw_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .STARVE_LIMIT(SL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_mask   (wr_req_mask),
        .sram_addr     (sram_addr),
        .sram_en       (sram_en),
        .sram_wmode    (sram_wmode),
        .sram_wmask    (sram_wmask),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .init_done     (init_done)
    );

    // Power-up contents of the macro (deterministic, non-zero pattern).
    function automatic logic [DW-1:0] seed_val(input int i);
        logic [31:0] t;
        t = i * 32'h9E37_79B1;
        t = t ^ 32'h0005_A5A5;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_v;
        for (int g = 0; g < MW; g++) begin
            if (m[g]) r[g*GW +: GW] = new_v[g*GW +: GW];
        end
        return r;
    endfunction

    // ---------------- macro model: 1RW, registered read ----------------
    logic [DW-1:0] sram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = seed_val(i);
        sram_rdata = '0;
        forever begin
            @(posedge clock);
            if (sram_en) begin
                if (sram_wmode) begin
                    sram_mem[sram_addr] = merge(sram_mem[sram_addr], sram_wdata, sram_wmask);
                end else begin
                    sram_rdata <= sram_mem[sram_addr];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        bit            resp_due;
    } exp_t;

    exp_t          cyc_q[$];
    logic [DW-1:0] rd_q[$];
    bit            sb_en = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_txn = 0;

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            starve = 0;
    bit            pend_rd = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    endtask

    task automatic drive(input bit rv, input logic [AW-1:0] ra,
                         input bit wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        exp_t e;
        @(negedge clock);
        sb_en        = 1'b1;
        rd_req_valid = rv;
        rd_req_addr  = ra;
        wr_req_valid = wv;
        wr_req_addr  = wa;
        wr_req_data  = wd;
        wr_req_mask  = wm;
        e.resp_due = pend_rd;
        pend_rd    = 1'b0;
        e.rd = 1'b0;
        e.wr = 1'b0;
        e.addr = '0;
        e.wdata = wd;
        e.wmask = wm;
        if (wv && (!rv || starve >= SL || ra == wa)) e.wr = 1'b1;
        else if (rv) e.rd = 1'b1;
        if (wv && !e.wr) starve = (starve + 1 > SL) ? SL : starve + 1;
        else starve = 0;
        if (e.wr) begin
            e.addr = wa;
            ref_mem[wa] = merge(ref_mem[wa], wd, wm);
            n_txn++;
            $display("txn %0d: WR addr=0x%03h data=0x%05h mask=0x%03h", n_txn, wa, wd, wm);
        end else if (e.rd) begin
            e.addr = ra;
            rd_q.push_back(ref_mem[ra]);
            pend_rd = 1'b1;
            n_txn++;
            $display("txn %0d: RD addr=0x%03h expect=0x%05h", n_txn, ra, ref_mem[ra]);
        end
        cyc_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clock);
        #2;
        if (sb_en) begin
            if (cyc_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: no expected entry @%0t", $time);
            end else begin
                e = cyc_q.pop_front();
                check("rd_req_ready", rd_req_ready, e.rd);
                check("wr_req_ready", wr_req_ready, e.wr);
                check("sram_en", sram_en, e.rd | e.wr);
                if (e.rd | e.wr) begin
                    check("sram_addr", sram_addr, e.addr);
                    check("sram_wmode", sram_wmode, e.wr);
                end
                if (e.wr) begin
                    check("sram_wdata", sram_wdata, e.wdata);
                    check("sram_wmask", sram_wmask, e.wmask);
                end
                check("rd_resp_valid", rd_resp_valid, e.resp_due);
                if (rd_resp_valid) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rd_resp_unexpected: got 0x%05h expected none", rd_resp_data);
                    end else begin
                        check("rd_resp_data", rd_resp_data, rd_q.pop_front());
                    end
                end
            end
        end
    end

    // Release reset at a falling edge and follow INIT until init_done rises.
    task automatic release_and_init(input string tag);
        int n;
        int errs;
        @(negedge clock);
        reset        = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 10'd5;
        wr_req_valid = 1'b0;
        n    = 1;
        errs = 0;
        while (n <= 1100) begin
            #2;
            if (init_done) break;
            if (rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0) errs++;
`ifdef SRAM_ARB_INIT_CLEAR_EN
            if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== AW'(n - 1) ||
                sram_wmask !== {MW{1'b1}} || sram_wdata !== '0) errs++;
`else
            if (sram_en !== 1'b0) errs++;
`endif
            @(negedge clock);
            n++;
        end
        rd_req_valid = 1'b0;
        check({tag, "_init_done_cycle"}, n, EXP_INIT_N);
        check({tag, "_init_cmd_errs"}, errs, 0);
        starve  = 0;
        pend_rd = 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [AW-1:0] ra, wa;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);

        // reset values, with both requests asserted
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        #1;
        check("rst_rd_ready", rd_req_ready, 0);
        check("rst_wr_ready", wr_req_ready, 0);
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_wmode", sram_wmode, 0);
        check("rst_init_done", init_done, 0);
        repeat (2) @(negedge clock);
        release_and_init("boot");

        // read priority then starvation-forced write
        repeat (5) drive(1'b1, 10'd5, 1'b1, 10'd9, 20'h1234_5, 10'h3FF);
        drive(1'b1, 10'd5, 1'b1, 10'd9, 20'h0000_F, 10'h3FF);
        idle();
        // same-address ordering
        drive(1'b1, 10'd3, 1'b1, 10'd3, 20'hABCDE, 10'h3FF);
        drive(1'b1, 10'd3, 1'b0, '0, '0, '0);
        idle();
        // partial mask
        drive(1'b0, '0, 1'b1, 10'd7, 20'hFFFFF, 10'h3FF);
        drive(1'b0, '0, 1'b1, 10'd7, 20'h00000, 10'h001);
        drive(1'b1, 10'd7, 1'b0, '0, '0, '0);
        // zero-mask write changes nothing
        drive(1'b0, '0, 1'b1, 10'd20, 20'h12345, 10'h000);
        drive(1'b1, 10'd20, 1'b0, '0, '0, '0);
        // back-to-back reads
        drive(1'b1, 10'd0, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd1, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd2, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd1023, 1'b0, '0, '0, '0);
        idle();

        // randomized traffic over a small hot address set plus the full range
        for (int c = 0; c < 800; c++) begin
            ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            wa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < 75, ra,
                  $urandom_range(0, 99) < 55, wa,
                  DW'($urandom), MW'($urandom));
        end
        idle();

        // reset while a read response is in flight
        drive(1'b1, 10'd3, 1'b0, '0, '0, '0);
        @(negedge clock);
        sb_en        = 1'b0;
        rd_req_valid = 1'b0;
        check("pre_rst_resp_valid", rd_resp_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_resp_valid", rd_resp_valid, 0);
        check("mid_rst_sram_en", sram_en, 0);
        check("mid_rst_init_done", init_done, 0);
        cyc_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clock);
        release_and_init("rerun");

        // normal traffic after the second init
        drive(1'b0, '0, 1'b1, 10'd11, 20'h5A5A5, 10'h3FF);
        drive(1'b1, 10'd11, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd12, 1'b0, '0, '0, '0);
        idle();
        @(negedge clock);
        sb_en = 1'b0;
        #3;
        check("end_cyc_q_size", cyc_q.size(), 0);
        check("end_rd_q_size", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
